// File: rtl/inv_sub_shift_rows.sv
// AES decryption round stage: InvShiftRows at capture, then InvSubBytes over 16/BYTES_PER_CYCLE cycles.
// Latency: out_valid rises 16/BYTES_PER_CYCLE cycles after the accepting edge; one job in flight at a time.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE. Optional macro INV_SUB_ROUNDKEY_EN.

// Combinational AES inverse S-box lookup.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 sits in the top byte of the table.
  assign y = TBL[2047 - 8*int'(a) -: 8];
endmodule

module inv_sub_shift_rows #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef INV_SUB_ROUNDKEY_EN
  ,
  input  logic [127:0] round_key
`endif
);

  localparam int N     = BYTES_PER_CYCLE;
  localparam bit BAD_N = (N < 1 || N > 16) ? 1'b1 : ((16 % N) != 0);
  localparam int STEPS = BAD_N ? 1 : 16 / N;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (BAD_N) begin : g_bad_param
    $error("inv_sub_shift_rows: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [127:0]  data_q;
  logic [127:0]  data_nxt;
  logic [7:0]    sbox_in  [N];
  logic [7:0]    sbox_out [N];

  // Byte i is row i%4, column i/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  // Route the byte group selected by cnt into the S-box bank.
  always_comb begin
    for (int j = 0; j < N; j++) sbox_in[j] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (cnt == CW'(k / N)) sbox_in[k % N] = data_q[127 - 8*k -: 8];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .a (sbox_in[j]),
      .y (sbox_out[j])
    );
  end

  // Write substituted bytes back in place; other groups pass through.
  always_comb begin
    data_nxt = data_q;
    for (int k = 0; k < 16; k++) begin
      if (cnt == CW'(k / N)) data_nxt[127 - 8*k -: 8] = sbox_out[k % N];
    end
  end

`ifdef INV_SUB_ROUNDKEY_EN
  logic [127:0] key_q;

  // Key is captured together with the state so it stays paired with its job.
  always_ff @(posedge clk) begin
    if (rst) key_q <= '0;
    else if (state == S_IDLE && in_valid) key_q <= round_key;
  end

  assign out_state = data_q ^ key_q;
`else
  assign out_state = data_q;
`endif

  // Job FSM: capture shifted state, substitute group by group, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= inv_shift_rows(in_state);
            cnt    <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          data_q <= data_nxt;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_inv_sub_shift_rows.sv
// Bench for inv_sub_shift_rows: reference model built from GF(2^8) arithmetic, per-cycle compare,
// directed literal vectors, and latency checks on BYTES_PER_CYCLE = 4, 1 and 16.
module tb_inv_sub_shift_rows;
  localparam int L = 4;
  localparam logic [127:0] V2   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] E2   = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] EZ   = 128'h52525252525252525252525252525252;
  localparam logic [127:0] KF   = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] E2K  = 128'hfff2f5f8fbfef1f4f7fafdf0f3f6f9fc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_state, out_state, round_key;

  logic         a_valid [2];
  logic         a_ready [2];
  logic         a_ovalid[2];
  logic         a_oready[2];
  logic [127:0] a_in    [2];
  logic [127:0] a_out   [2];
  logic [127:0] a_key   [2];

  int tests = 0;
  int fails = 0;

  inv_sub_shift_rows #(.BYTES_PER_CYCLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
`ifdef INV_SUB_ROUNDKEY_EN
    ,
    .round_key (round_key)
`endif
  );

  for (genvar g = 0; g < 2; g++) begin : g_alt
    inv_sub_shift_rows #(.BYTES_PER_CYCLE(g == 0 ? 1 : 16)) u_alt (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_valid[g]),
      .in_ready  (a_ready[g]),
      .in_state  (a_in[g]),
      .out_valid (a_ovalid[g]),
      .out_ready (a_oready[g]),
      .out_state (a_out[g])
`ifdef INV_SUB_ROUNDKEY_EN
      ,
      .round_key (a_key[g])
`endif
    );
  end

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] inv_tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Forward S-box from multiplicative inverse + affine map, then inverted.
  task automatic build_tables;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [127:0] key);
    logic [127:0] o, k;
    int src;
`ifdef INV_SUB_ROUNDKEY_EN
    k = key;
`else
    k = '0;
`endif
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = r + 4*((c - r + 4) % 4);
        o[127 - 8*(r + 4*c) -: 8] = inv_tbl[s[127 - 8*src -: 8]] ^ k[127 - 8*(r + 4*c) -: 8];
      end
    return o;
  endfunction

  // Transaction-level model: one job outstanding, result visible L edges after capture.
  int           cyc = 0;
  int           t_acc = 0;
  bit           have = 0;
  bit           seen_rst = 0;
  bit           rst_last = 0;
  logic [127:0] exp_out = '0;
  int           acc_q[$];
  bit           ev;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      have = 0; exp_out = '0; rst_last = 1; seen_rst = 1;
    end else begin
      rst_last = 0;
      if (have) begin
        if ((cyc - 1 - t_acc) >= L && out_ready) have = 0;
      end else if (in_valid) begin
        have = 1;
        t_acc = cyc;
        exp_out = ref_out(in_state, round_key);
        acc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      ev = have && ((cyc - t_acc) >= L);
      check("cyc_in_ready", 128'(in_ready), 128'(!have));
      check("cyc_out_valid", 128'(out_valid), 128'(ev));
      if (ev || rst_last) check("cyc_out_state", out_state, exp_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send_main(input string nm, input logic [127:0] vec, input logic [127:0] key,
                           input logic [127:0] exp);
    int lat;
    in_state = vec; round_key = key; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick; lat++; end
    check({nm, "_latency"}, 128'(lat), 128'(L));
    check({nm, "_out"}, out_state, exp);
    tick;
  endtask

  task automatic send_alt(input int g, input logic [127:0] vec, input logic [127:0] exp, input int lat_e);
    int lat;
    check($sformatf("alt%0d_in_ready", lat_e), 128'(a_ready[g]), 128'(1));
    a_in[g] = vec; a_valid[g] = 1'b1;
    tick;
    a_valid[g] = 1'b0;
    lat = 0;
    while (!a_ovalid[g] && lat < 40) begin tick; lat++; end
    check($sformatf("alt%0d_latency", lat_e), 128'(lat), 128'(lat_e));
    check($sformatf("alt%0d_out", lat_e), a_out[g], exp);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, cnt_v, w;
    logic [127:0] hold;

    build_tables;
    check("model_vec2", ref_out(V2, '0), E2);
    check("model_zero", ref_out('0, '0), EZ);
`ifdef INV_SUB_ROUNDKEY_EN
    check("model_key", ref_out(V2, KF), E2K);
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_state = '0; round_key = '0;
    for (int g = 0; g < 2; g++) begin
      a_valid[g] = 1'b0; a_oready[g] = 1'b1; a_in[g] = '0; a_key[g] = '0;
    end
    tick; tick;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, '0);
    rst = 1'b0;
    tick;

    send_main("vec2", V2, '0, E2);
    send_main("zero", '0, '0, EZ);
`ifdef INV_SUB_ROUNDKEY_EN
    send_main("vec2_key", V2, KF, E2K);
`endif

    send_alt(0, '0, EZ, 16);
    send_alt(0, V2, E2, 16);
    send_alt(1, '0, EZ, 1);
    send_alt(1, V2, E2, 1);

    // Reset while busy discards the job.
    in_state = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_busy_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy_out_valid", 128'(out_valid), 128'(0));
    cnt_v = 0;
    repeat (8) begin tick; if (out_valid) cnt_v++; end
    check("rst_busy_never_valid", 128'(cnt_v), 128'(0));

    // Backpressure: result held, extra in_valid pulses ignored.
    out_ready = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom}; round_key = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin tick; w++; end
    check("bp_reached_done", 128'(out_valid), 128'(1));
    hold = out_state;
    n0 = acc_q.size();
    repeat (10) begin
      in_valid = 1'($urandom % 2);
      in_state = {$urandom, $urandom, $urandom, $urandom};
      tick;
      check("bp_out_state_stable", out_state, hold);
      check("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    check("bp_no_second_capture", 128'(acc_q.size()), 128'(n0));
    check("bp_released_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back with in_valid held high.
    n0 = acc_q.size();
    in_state = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    tick;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    w = 0;
    while (acc_q.size() < n0 + 2 && w < 40) begin tick; w++; end
    in_valid = 1'b0;
    check("b2b_two_accepts", 128'(acc_q.size()), 128'(n0 + 2));
    if (acc_q.size() >= n0 + 2)
      check("b2b_accept_spacing", 128'(acc_q[n0 + 1] - acc_q[n0]), 128'(L + 2));
    repeat (8) tick;

    // Random traffic, checked cycle by cycle against the model.
    repeat (300) begin
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      round_key = {$urandom, $urandom, $urandom, $urandom};
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
